// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and timing defaults for the serial link
package serial_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_RDY, GUARD, BIT_HIGH, BIT_LOW} tx_state_t;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_HIGH_CYCLES = 10;
  localparam int DEF_LOW_CYCLES  = 10;
  localparam int DEF_START_DELAY = 10;
  function automatic int cnt_width(input int h, input int l, input int s);
    int m;
    m = (h > l) ? h : l;
    m = (m > s) ? m : s;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/tx_phase_counter.sv
// tx_phase_counter: down-counter timing one protocol phase; tc_o marks its last cycle
module tx_phase_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             tc_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  assign cnt_d = load_i ? value_i : ((cnt_q == '0) ? cnt_q : cnt_q - 1'b1);
  assign tc_o  = (cnt_q == '0);
  // loading N-1 on phase entry keeps the phase active for exactly N cycles
  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/serializer_tx.sv
// serializer_tx: holds one parallel word and shifts it out LSB first with timed write strobes
module serializer_tx
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int LOW_CYCLES  = DEF_LOW_CYCLES,
  parameter int START_DELAY = DEF_START_DELAY
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  status_in,
  output logic                  data_out,
  output logic                  write_out,
  output logic                  busy_out,
  output logic                  done_out
);
  localparam int CW = cnt_width(HIGH_CYCLES, LOW_CYCLES, START_DELAY);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] HI_LD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LO_LD = CW'(LOW_CYCLES - 1);
  localparam logic [CW-1:0] SD_LD = CW'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [IW-1:0] LAST  = IW'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, shift_q, shift_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_val;
  logic                  hold_valid_q, hold_valid_d, data_q, data_d, write_q, done_q, done_d;
  logic                  hold_load, cnt_load, cnt_tc, accept;

  tx_phase_counter #(.WIDTH(CW)) u_cnt (
    .clock   (clock),
    .reset   (reset),
    .load_i  (cnt_load),
    .value_i (cnt_val),
    .tc_o    (cnt_tc)
  );

  // the engine draining the holding register frees it in the same cycle
  assign in_ready     = !hold_valid_q || hold_load;
  assign accept       = in_valid && in_ready;
  assign hold_valid_d = accept || (hold_valid_q && !hold_load);
  assign hold_d       = accept ? in_data : hold_q;
  assign data_d       = (state_d == BIT_HIGH && state_q != BIT_HIGH) ? shift_d[0] : data_q;
  assign data_out     = data_q;
  assign write_out    = write_q;
  assign done_out     = done_q;
  assign busy_out     = (state_q != IDLE);

  // next-state, shift/index update and phase counter reloads
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    hold_load = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (hold_valid_q) begin
        hold_load = 1'b1;
        shift_d   = hold_q;
        idx_d     = '0;
        state_d   = WAIT_RDY;
      end
      WAIT_RDY: if (status_in) begin
        cnt_load = 1'b1;
        cnt_val  = (START_DELAY == 0) ? HI_LD : SD_LD;
        state_d  = (START_DELAY == 0) ? BIT_HIGH : GUARD;
      end
      GUARD: if (cnt_tc) begin
        cnt_load = 1'b1;
        cnt_val  = HI_LD;
        state_d  = BIT_HIGH;
      end
      BIT_HIGH: if (cnt_tc) begin
        cnt_load = 1'b1;
        cnt_val  = LO_LD;
        state_d  = BIT_LOW;
      end
      BIT_LOW: if (cnt_tc) begin
        if (idx_q != LAST) begin
          shift_d  = shift_q >> 1;
          idx_d    = idx_q + 1'b1;
          cnt_load = 1'b1;
          cnt_val  = HI_LD;
          state_d  = BIT_HIGH;
        end else begin
          done_d = 1'b1;
          if (hold_valid_q) begin
            hold_load = 1'b1;
            shift_d   = hold_q;
            idx_d     = '0;
            state_d   = WAIT_RDY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // registered state and outputs so write_out/data_out never glitch
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      idx_q        <= '0;
      data_q       <= 1'b0;
      write_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      write_q      <= (state_d == BIT_HIGH);
      done_q       <= done_d;
    end
  end
endmodule

// File: tb/tb_serializer_tx.sv
// tb_serializer_tx: scoreboard bench decoding the serial stream back into words
module tb_serializer_tx;
  localparam int W = 8, HIGH = 10, LOW = 10, SD = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         status_in = 1'b0;
  logic         in_ready, data_out, write_out, busy_out, done_out;

  logic         reset2 = 1'b0;
  logic [7:0]   in_data2 = '0;
  logic         in_valid2 = 1'b0;
  logic         status2 = 1'b0;
  logic         in_ready2, data2, write2, busy2, done2;

  int           checks = 0, errors = 0, cyc = 0;
  bit           rand_on = 1'b0;
  logic [W-1:0] exp_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  serializer_tx #(.DATA_WIDTH(W), .HIGH_CYCLES(HIGH), .LOW_CYCLES(LOW), .START_DELAY(SD)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .status_in(status_in), .data_out(data_out), .write_out(write_out), .busy_out(busy_out),
    .done_out(done_out)
  );

  serializer_tx #(.DATA_WIDTH(8), .HIGH_CYCLES(1), .LOW_CYCLES(1), .START_DELAY(0)) dut_fast (
    .clock(clock), .reset(reset2), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .status_in(status2), .data_out(data2), .write_out(write2), .busy_out(busy2), .done_out(done2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // offer a word until the handshake completes; the accepted word becomes an expectation
  task automatic send(input logic [W-1:0] w, output int at);
    bit acc = 1'b0;
    int n = 0;
    at = -1;
    in_data = w;
    in_valid = 1'b1;
    while (!acc && n < 3000) begin
      @(negedge clock);
      acc = in_ready && reset;
      @(posedge clock);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("send_accept", acc, 1);
    if (acc) begin
      exp_q.push_back(w);
      at = cyc;
    end
  endtask

  // sel 0: done_out high, 1: write_out high, 2: write_out low
  task automatic wait_for(input int sel, input int bound, output int at);
    bit hit = 1'b0;
    int n = 0;
    at = -1;
    while (!hit && n < bound) begin
      @(negedge clock);
      n++;
      hit = (sel == 0) ? done_out : (sel == 1) ? write_out : !write_out;
    end
    chk("wait_timeout", hit, 1);
    if (hit) at = cyc;
  endtask

  // far-end model: rebuild words from strobes, check phase lengths and compare with the queue
  initial begin : monitor
    logic         prev_w = 1'b0, cur = 1'b0;
    int           hi_len = 0, lo_len = 0, nbits = 0;
    logic [W-1:0] word = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_w = 1'b0;
        nbits = 0;
        hi_len = 0;
        lo_len = 0;
        exp_q.delete();
      end else begin
        if (done_out) begin
          chk("done_after_bits", nbits, W);
          chk("last_low_len", lo_len, LOW);
          chk("word_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("word", word, exp_q.pop_front());
          nbits = 0;
          lo_len = 0;
        end else if (write_out) begin
          if (!prev_w) begin
            if (nbits > 0) chk("low_len", lo_len, LOW);
            hi_len = 0;
            lo_len = 0;
            cur = data_out;
            if (nbits < W) word[nbits] = data_out;
            nbits++;
          end
          hi_len++;
          chk("data_stable_high", data_out, cur);
        end else if (nbits > 0) begin
          if (prev_w) chk("high_len", hi_len, HIGH);
          lo_len++;
          chk("data_stable_low", data_out, cur);
          if (nbits == W && lo_len == LOW + 1) chk("done_missing", done_out, 1);
        end
        prev_w = write_out;
      end
    end
  end

  initial begin : stim
    int ca, cb, at, c0, d1, n_hi, n, strobes, ones, dones, first, done_at;
    logic pw;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_write", write_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    status_in = 1'b1;

    // accept edge, load edge, then the next edge sees status high and starts the 170-cycle word
    send(8'h99, ca);
    wait_for(0, 400, at);
    chk("t1_done_time", at - ca, 172);
    chk("t1_idle_after", busy_out, 0);
    @(posedge clock);
    #1;

    send(8'h99, ca);
    send(8'hF0, cb);
    chk("t2_b2b_accept", cb - ca, 1);
    @(negedge clock);
    chk("t2_in_ready_low", in_ready, 0);
    chk("t2_busy", busy_out, 1);
    wait_for(0, 400, d1);
    chk("t2_first_done", d1 - ca, 172);
    wait_for(0, 400, at);
    chk("t2_second_done", at - d1, 171);
    @(posedge clock);
    #1;

    status_in = 1'b0;
    send(8'h3C, ca);
    n_hi = 0;
    repeat (50) begin
      @(negedge clock);
      n_hi += int'(write_out);
    end
    chk("t3_no_strobe", n_hi, 0);
    chk("t3_busy_waiting", busy_out, 1);
    chk("t3_hold_free", in_ready, 1);
    @(posedge clock);
    #1;
    c0 = cyc;
    status_in = 1'b1;
    wait_for(1, 100, at);
    chk("t3_first_strobe", at - c0, 11);
    wait_for(0, 400, at);
    chk("t3_done", at - c0, 171);
    @(posedge clock);
    #1;

    send(W'($urandom), ca);
    wait_for(1, 100, at);
    repeat (3) begin
      wait_for(2, 100, at);
      wait_for(1, 100, at);
    end
    @(posedge clock);
    #1;
    status_in = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    status_in = 1'b1;
    wait_for(0, 400, at);
    chk("t4_done_time", at - ca, 172);
    @(posedge clock);
    #1;

    send(W'($urandom), ca);
    wait_for(1, 100, at);
    repeat (4) begin
      wait_for(2, 100, at);
      wait_for(1, 100, at);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("t5_write", write_out, 0);
    chk("t5_data", data_out, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_busy", busy_out, 0);
    chk("t5_done", done_out, 0);
    @(negedge clock);
    chk("t5_done_held", done_out, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    send(8'hA5, ca);
    wait_for(0, 400, at);
    chk("t5_a5_done", at - ca, 172);
    @(posedge clock);
    #1;

    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          int gap;
          gap = $urandom_range(0, 30);
          repeat (gap) begin
            @(posedge clock);
            #1;
          end
          send(W'($urandom), ca);
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clock);
          #1;
          status_in = ($urandom_range(0, 3) != 0);
        end
      end
    join
    status_in = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk("drain", exp_q.size(), 0);

    @(posedge clock);
    #1;
    reset2 = 1'b1;
    in_data2 = 8'h01;
    in_valid2 = 1'b1;
    @(posedge clock);
    #1;
    in_valid2 = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    chk("fast_waiting", busy2, 1);
    c0 = cyc;
    status2 = 1'b1;
    strobes = 0;
    ones = 0;
    dones = 0;
    first = -1;
    done_at = -1;
    pw = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (write2 && !pw) begin
        strobes++;
        if (first < 0) first = cyc;
      end
      if (write2 && data2) ones++;
      if (done2) begin
        dones++;
        done_at = cyc;
      end
      pw = write2;
    end
    chk("fast_first_strobe", first - c0, 1);
    chk("fast_strobes", strobes, 8);
    chk("fast_ones", ones, 1);
    chk("fast_dones", dones, 1);
    chk("fast_done_time", done_at - c0, 17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
